// File: rtl/audio_clip_player.sv
// rtl/audio_clip_player.sv - plays one PCM clip from sample memory to the codec, optional looping via AUDIO_CLIP_LOOP_EN
module audio_clip_player #(
  parameter int CLIP_LEN = 150000,
  parameter int ADDR_W   = 18,
  parameter int DATA_W   = 16,
  parameter int TICK_DIV = 1042
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              play,
  input  logic              stop,
  input  logic [1:0]        vol_shift,
`ifdef AUDIO_CLIP_LOOP_EN
  input  logic              loop_en,
`endif
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [DATA_W-1:0] sample_data,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              busy,
  output logic              done,
  output logic              underrun
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(CLIP_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LATCH,
    S_HOLD,
    S_WAIT_TICK
  } state_t;

  state_t                    r_state;
  state_t                    w_state_next;
  logic [ADDR_W-1:0]         r_addr;
  logic [CNT_W-1:0]          r_cnt;
  logic [DATA_W-1:0]         r_sample;
  logic                      r_valid;
  logic                      r_done;
  logic                      r_underrun;
  logic                      w_tick;
  logic                      w_accept;
  logic                      w_last;
  logic                      w_loop;
  logic                      w_restart;
  logic signed [DATA_W-1:0]  w_shifted;

`ifdef AUDIO_CLIP_LOOP_EN
  assign w_loop = loop_en;
`else
  assign w_loop = 1'b0;
`endif

  // stop beats play; play restarts from any state
  assign w_restart = play & ~stop;
  assign w_tick    = (r_cnt == TICK_LAST);
  assign w_accept  = (r_state == S_HOLD) & r_valid & sample_ready;
  assign w_last    = (r_addr == ADDR_LAST);
  assign w_shifted = $signed(mem_readdata) >>> vol_shift;

  assign mem_address    = r_addr;
  assign mem_chipselect = (r_state == S_READ);
  assign mem_clken      = (r_state != S_IDLE);
  assign busy           = (r_state != S_IDLE);
  assign sample_data    = r_sample;
  assign sample_valid   = r_valid;
  assign done           = r_done;
  assign underrun       = r_underrun;

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // next-state: abort and retrigger override the normal fetch sequence
  always_comb begin
    w_state_next = r_state;
    if (r_state == S_IDLE) begin
      if (w_restart) w_state_next = S_READ;
    end else if (stop) begin
      w_state_next = S_IDLE;
    end else if (play) begin
      w_state_next = S_READ;
    end else begin
      case (r_state)
        S_READ:      w_state_next = S_LATCH;
        S_LATCH:     w_state_next = S_HOLD;
        S_HOLD: begin
          if (w_accept) begin
            if (w_last && !w_loop) w_state_next = S_IDLE;
            else                   w_state_next = S_WAIT_TICK;
          end
        end
        S_WAIT_TICK: if (w_tick) w_state_next = S_READ;
        default:     w_state_next = S_IDLE;
      endcase
    end
  end

  // sample-period counter: free-runs while busy, zeroed on (re)start and whenever idle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                  r_cnt <= '0;
    else if (w_restart || w_state_next == S_IDLE)  r_cnt <= '0;
    else if (w_tick)                               r_cnt <= '0;
    else                                           r_cnt <= r_cnt + CNT_W'(1);
  end

  // datapath: address walk, sample latch/handshake, done pulse and sticky underrun
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr     <= '0;
      r_sample   <= '0;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (stop) begin
        r_valid <= 1'b0;
      end else if (play) begin
        r_addr     <= '0;
        r_valid    <= 1'b0;
        r_underrun <= 1'b0;
      end else begin
        case (r_state)
          S_LATCH: begin
            r_sample <= w_shifted;
            r_valid  <= 1'b1;
          end
          S_HOLD: begin
            if (w_accept) begin
              r_valid <= 1'b0;
              if (w_last) begin
                r_done <= 1'b1;
                if (w_loop) r_addr <= '0;
              end else begin
                r_addr <= r_addr + ADDR_W'(1);
              end
            end else if (w_tick) begin
              r_underrun <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_audio_clip_player.sv
// tb/tb_audio_clip_player.sv - scoreboard bench for audio_clip_player (4-sample clip, 8-cycle tick)
module tb_audio_clip_player;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        play = 1'b0;
  logic        stop = 1'b0;
  logic [1:0]  vol_shift = 2'd0;
  logic        loop_en = 1'b0;
  logic [17:0] mem_address;
  logic        mem_chipselect;
  logic        mem_clken;
  logic [15:0] mem_readdata;
  logic [15:0] sample_data;
  logic        sample_valid;
  logic        sample_ready = 1'b1;
  logic        busy;
  logic        done;
  logic        underrun;

  audio_clip_player #(.CLIP_LEN(4), .ADDR_W(18), .DATA_W(16), .TICK_DIV(8)) dut (
    .clk(clk), .reset_n(reset_n), .play(play), .stop(stop), .vol_shift(vol_shift),
`ifdef AUDIO_CLIP_LOOP_EN
    .loop_en(loop_en),
`endif
    .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .sample_data(sample_data), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .busy(busy), .done(done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [4];
  initial begin
    rom[0] = 16'h1000; rom[1] = 16'h8000; rom[2] = 16'h7FFF; rom[3] = 16'hFFFF;
  end
  // sample memory: registered address, one-cycle read latency
  always @(posedge clk) mem_readdata <= rom[mem_address[1:0]];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc++;

  logic [15:0] exp_q [$];
  int          addr_q [$];
  int          acc_cyc [$];
  int          n_done = 0;
  int          done_cyc = 0;
  logic        busy_at_done = 1'b0;
  logic        prev_done = 1'b0;
  logic        prev_hold = 1'b0;
  logic [15:0] prev_data = 16'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // monitor: memory reads, accepted samples, hold stability, done pulses
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_hold = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (mem_chipselect) begin
        if (addr_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_read: address %0d, none expected", mem_address);
        end else begin
          check("read_addr", 32'(mem_address), 32'(addr_q.pop_front()));
        end
      end
      if (prev_hold) begin
        check("hold_valid", 32'(sample_valid), 32'd1);
        check("hold_data", 32'(sample_data), 32'(prev_data));
      end
      prev_hold = sample_valid && !sample_ready && !stop && !play;
      prev_data = sample_data;
      if (sample_valid && sample_ready) begin
        acc_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_sample: data %0h, none expected", sample_data);
        end else begin
          check("sample_data", 32'(sample_data), 32'(exp_q.pop_front()));
        end
      end
      if (done) begin
        if (prev_done) begin
          n_tests++; n_fail++;
          $display("FAIL done_width: done high 2 cycles, expected 1");
        end
        n_done++;
        done_cyc = cyc;
        busy_at_done = busy;
      end
      prev_done = done;
    end
  end

  typedef struct {
    logic [1:0]       shift;
    logic [3:0][15:0] exp;
  } vec_t;
  vec_t vecs [4];

  task automatic tick_n(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_run(input logic [3:0][15:0] ex, input int ns, input int na);
    for (int k = 0; k < ns; k++) exp_q.push_back(ex[k]);
    for (int k = 0; k < na; k++) addr_q.push_back(k);
  endtask

  task automatic pulse_play(output int pc);
    play = 1'b1; pc = cyc; tick_n(1); play = 1'b0;
  endtask

  task automatic wait_acc(input int n, input string name);
    for (int i = 0; i < 200 && acc_cyc.size() < n; i++) tick_n(1);
    check(name, 32'(acc_cyc.size() >= n), 32'd1);
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 100 && !sample_valid; i++) tick_n(1);
    check(name, 32'(sample_valid), 32'd1);
  endtask

  task automatic wait_done(input int d0, input string name);
    for (int i = 0; i < 200 && n_done == d0; i++) tick_n(1);
    check(name, 32'(n_done - d0), 32'd1);
  endtask

  logic [3:0][15:0] plain;
  int pc;
  int d0;

  initial begin
    vecs[0].shift = 2'd0; vecs[0].exp = {16'hFFFF, 16'h7FFF, 16'h8000, 16'h1000};
    vecs[1].shift = 2'd2; vecs[1].exp = {16'hFFFF, 16'h1FFF, 16'hE000, 16'h0400};
    vecs[2].shift = 2'd1; vecs[2].exp = {16'hFFFF, 16'h3FFF, 16'hC000, 16'h0800};
    vecs[3].shift = 2'd3; vecs[3].exp = {16'hFFFF, 16'h0FFF, 16'hF000, 16'h0200};
    plain = vecs[0].exp;

    // reset state
    tick_n(3);
    check("rst_addr", 32'(mem_address), 0);
    check("rst_cs", 32'(mem_chipselect), 0);
    check("rst_clken", 32'(mem_clken), 0);
    check("rst_data", 32'(sample_data), 0);
    check("rst_valid", 32'(sample_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_underrun", 32'(underrun), 0);
    reset_n = 1'b1;
    tick_n(2);

    // full clips at each attenuation, ready tied high
    for (int v = 0; v < 4; v++) begin
      vol_shift = vecs[v].shift;
      push_run(vecs[v].exp, 4, 4);
      acc_cyc.delete();
      d0 = n_done;
      pulse_play(pc);
      wait_done(d0, "clip_done");
      check("clip_count", 32'(acc_cyc.size()), 4);
      if (acc_cyc.size() == 4) begin
        check("first_latency", 32'(acc_cyc[0] - pc), 3);
        for (int k = 1; k < 4; k++) check("spacing", 32'(acc_cyc[k] - acc_cyc[k-1]), 8);
        check("done_cycle", 32'(done_cyc), 32'(acc_cyc[3] + 1));
      end
      check("busy_at_done", 32'(busy_at_done), 0);
      tick_n(12);
      check("single_done", 32'(n_done - d0), 1);
      check("clip_drained", 32'(exp_q.size() + addr_q.size()), 0);
      check("idle_after", 32'(busy), 0);
    end

    // ready held low 20 cycles on sample 1
    vol_shift = 2'd0;
    push_run(plain, 4, 4);
    acc_cyc.delete();
    d0 = n_done;
    pulse_play(pc);
    wait_acc(1, "ur_first");
    sample_ready = 1'b0;
    wait_valid("ur_valid");
    tick_n(20);
    check("ur_sticky", 32'(underrun), 1);
    check("ur_held_data", 32'(sample_data), 32'h8000);
    sample_ready = 1'b1;
    wait_done(d0, "ur_done");
    tick_n(4);
    check("ur_drained", 32'(exp_q.size() + addr_q.size()), 0);
    check("ur_still_set", 32'(underrun), 1);

    // stop during HOLD of sample 2
    push_run(plain, 2, 3);
    acc_cyc.delete();
    d0 = n_done;
    pulse_play(pc);
    wait_acc(2, "stop_acc");
    sample_ready = 1'b0;
    wait_valid("stop_valid");
    stop = 1'b1; tick_n(1); stop = 1'b0;
    check("stop_busy", 32'(busy), 0);
    check("stop_valid_low", 32'(sample_valid), 0);
    sample_ready = 1'b1;
    tick_n(30);
    check("stop_no_done", 32'(n_done - d0), 0);
    check("stop_drained", 32'(exp_q.size() + addr_q.size()), 0);

    // play and stop together from idle
    play = 1'b1; stop = 1'b1; tick_n(1); play = 1'b0; stop = 1'b0;
    tick_n(10);
    check("ps_idle", 32'(busy), 0);

    // retrigger while on sample 3 (underrun set earlier in this pass)
    push_run(plain, 3, 4);
    acc_cyc.delete();
    d0 = n_done;
    pulse_play(pc);
    wait_acc(1, "rt_acc1");
    sample_ready = 1'b0;
    tick_n(20);
    sample_ready = 1'b1;
    wait_acc(3, "rt_acc3");
    sample_ready = 1'b0;
    wait_valid("rt_valid");
    check("rt_ur_before", 32'(underrun), 1);
    push_run(plain, 4, 4);
    pulse_play(pc);
    check("rt_ur_cleared", 32'(underrun), 0);
    check("rt_valid_dropped", 32'(sample_valid), 0);
    sample_ready = 1'b1;
    wait_done(d0, "rt_done");
    tick_n(4);
    check("rt_drained", 32'(exp_q.size() + addr_q.size()), 0);

`ifdef AUDIO_CLIP_LOOP_EN
    // looping: two passes then stop
    loop_en = 1'b1;
    push_run(plain, 4, 4);
    push_run(plain, 4, 4);
    d0 = n_done;
    pulse_play(pc);
    for (int i = 0; i < 300 && n_done - d0 < 2; i++) tick_n(1);
    check("loop_dones", 32'(n_done - d0), 2);
    check("loop_busy", 32'(busy), 1);
    stop = 1'b1; tick_n(1); stop = 1'b0;
    check("loop_drained", 32'(exp_q.size() + addr_q.size()), 0);
`endif

    // asynchronous reset mid-playback
    push_run(plain, 4, 4);
    d0 = n_done;
    pulse_play(pc);
    wait_valid("ar_valid");
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    addr_q.delete();
    check("ar_valid", 32'(sample_valid), 0);
    check("ar_busy", 32'(busy), 0);
    check("ar_data", 32'(sample_data), 0);
    check("ar_addr", 32'(mem_address), 0);
    check("ar_clken", 32'(mem_clken), 0);
    tick_n(2);
    reset_n = 1'b1;
    tick_n(20);
    check("ar_no_done", 32'(n_done - d0), 0);
    check("ar_idle", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
